pc_stack_sequencer: RTL and testbench

- Parametrised successor to the 12-bit program counter.
- Adds a hardware return-address stack (call/return), sticky overflow/underflow error flags and configurable address width and stack depth.
- Sits between the decode ROM control outputs and the program memory address bus, and drives the fetch stage address.

---
 rtl/pc_stack_sequencer.sv | 104 ++++++++++
 tb/tb_pc_stack_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_sequencer.sv
// Program counter with a hardware return-address stack and sticky
// overflow/underflow flags; drives the fetch-stage address.
module pc_stack_sequencer #(
   parameter int ADDR_W      = 12,
   parameter int STACK_DEPTH = 4,
   parameter int DEPTH_W     = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_value,
   input  logic              call,
   input  logic              ret,
   input  logic              clear_flags,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] top,
   output logic [DEPTH_W-1:0] depth,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;
   logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
   logic [ADDR_W-1:0]  stack_d [STACK_DEPTH];
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_idx;
   logic [ADDR_W-1:0]  pc_inc;
   logic               full;
   logic               empty;

   assign full   = (depth_q == FULL_DEPTH);
   assign empty  = (depth_q == '0);
   assign wr_idx = IDX_W'(depth_q);
   assign rd_idx = IDX_W'(depth_q - DEPTH_W'(1));
   assign pc_inc = pc_q + ADDR_W'(1);

   // One action per cycle: ret > call > load > enable > hold
   always_comb begin
      pc_d        = pc_q;
      depth_d     = depth_q;
      overflow_d  = overflow_q & ~clear_flags;
      underflow_d = underflow_q & ~clear_flags;
      stack_d     = stack_q;
      if (ret) begin
         if (empty) begin
            underflow_d = 1'b1;
         end else begin
            pc_d    = stack_q[rd_idx];
            depth_d = depth_q - DEPTH_W'(1);
         end
      end else if (call) begin
         if (full) begin
            overflow_d = 1'b1;
         end else begin
            stack_d[wr_idx] = pc_inc;
            depth_d         = depth_q + DEPTH_W'(1);
            pc_d            = load_value;
         end
      end else if (load) begin
         pc_d = load_value;
      end else if (enable) begin
         pc_d = pc_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q        <= '0;
         depth_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         depth_q     <= depth_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not cleared by reset; a reset cycle just blocks the push
   always_ff @(posedge clk) begin
      if (reset) begin
         stack_q <= stack_d;
      end
   end

   assign pc          = pc_q;
   assign depth       = depth_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;
   assign stack_full  = full;
   assign stack_empty = empty;
   assign top         = empty ? '0 : stack_q[rd_idx];

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Directed-vector bench for pc_stack_sequencer (default parameters).
// Expected values are hand-computed per step.
module tb_pc_stack_sequencer;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        load;
   logic [11:0] load_value;
   logic        call;
   logic        ret;
   logic        clear_flags;
   logic [11:0] pc;
   logic [11:0] top;
   logic [2:0]  depth;
   logic        stack_full;
   logic        stack_empty;
   logic        overflow;
   logic        underflow;

   int n_checks = 0;
   int n_pass   = 0;

   pc_stack_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .load        (load),
      .load_value  (load_value),
      .call        (call),
      .ret         (ret),
      .clear_flags (clear_flags),
      .pc          (pc),
      .top         (top),
      .depth       (depth),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      reset       = 1'b1;
      enable      = 1'b0;
      load        = 1'b0;
      load_value  = '0;
      call        = 1'b0;
      ret         = 1'b0;
      clear_flags = 1'b0;
   endtask

   // Apply current inputs for one edge, then release them
   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      idle();
      #2;

      // reset overrides pending call/enable
      reset  = 1'b0;
      call   = 1'b1;
      enable = 1'b1;
      load_value = 12'h123;
      cyc();
      chk("rst_pc", pc, 0);
      chk("rst_depth", depth, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);
      chk("rst_empty", stack_empty, 1);
      chk("rst_top", top, 0);

      for (int i = 0; i < 5; i++) begin
         enable = 1'b1;
         cyc();
      end
      chk("inc5_pc", pc, 5);

      // load beats enable
      load = 1'b1; enable = 1'b1; load_value = 12'hFFF;
      cyc();
      chk("load_pc", pc, 12'hFFF);
      enable = 1'b1;
      cyc();
      chk("wrap_pc", pc, 0);

      load = 1'b1; load_value = 12'hFFF;
      cyc();
      call = 1'b1; load_value = 12'h100;
      cyc();
      chk("callwrap_top", top, 0);
      chk("callwrap_pc", pc, 12'h100);
      chk("callwrap_depth", depth, 1);
      ret = 1'b1;
      cyc();
      chk("retwrap_pc", pc, 0);
      chk("retwrap_depth", depth, 0);

      // nested call/return
      load = 1'b1; load_value = 12'h010;
      cyc();
      call = 1'b1; load_value = 12'h200;
      cyc();
      call = 1'b1; load_value = 12'h300;
      cyc();
      chk("nest_depth", depth, 2);
      chk("nest_top", top, 12'h201);
      chk("nest_pc", pc, 12'h300);
      ret = 1'b1;
      cyc();
      chk("ret1_pc", pc, 12'h201);
      chk("ret1_depth", depth, 1);
      chk("ret1_top", top, 12'h011);
      ret = 1'b1;
      cyc();
      chk("ret2_pc", pc, 12'h011);
      chk("ret2_depth", depth, 0);
      chk("ret2_empty", stack_empty, 1);
      chk("ret2_top", top, 0);

      // overflow
      load = 1'b1; load_value = 12'h000;
      cyc();
      for (int i = 0; i < 4; i++) begin
         call = 1'b1; load_value = 12'h000;
         cyc();
         chk("fill_full", stack_full, (i == 3) ? 1 : 0);
      end
      chk("fill_depth", depth, 4);
      chk("fill_top", top, 1);
      call = 1'b1; load_value = 12'h0AA;
      cyc();
      chk("ovf_pc", pc, 0);
      chk("ovf_depth", depth, 4);
      chk("ovf_flag", overflow, 1);
      enable = 1'b1;
      cyc();
      chk("ovf_sticky", overflow, 1);
      chk("ovf_sticky_pc", pc, 1);
      clear_flags = 1'b1;
      cyc();
      chk("clr_ovf", overflow, 0);
      chk("clr_depth", depth, 4);
      chk("clr_pc", pc, 1);
      for (int i = 0; i < 4; i++) begin
         ret = 1'b1;
         cyc();
         chk("drain_pc", pc, 1);
         chk("drain_depth", depth, 3 - i);
      end
      chk("drain_unf", underflow, 0);

      // underflow beats load
      ret = 1'b1; load = 1'b1; load_value = 12'h050;
      cyc();
      chk("unf_pc", pc, 1);
      chk("unf_flag", underflow, 1);
      chk("unf_depth", depth, 0);
      clear_flags = 1'b1;
      cyc();
      chk("clr_unf", underflow, 0);

      // ret beats call at depth 1
      call = 1'b1; load_value = 12'h400;
      cyc();
      chk("c1_top", top, 12'h002);
      chk("c1_pc", pc, 12'h400);
      call = 1'b1; ret = 1'b1; load_value = 12'h500;
      cyc();
      chk("cr_pc", pc, 12'h002);
      chk("cr_depth", depth, 0);
      chk("cr_ovf", overflow, 0);

      // set wins over clear
      ret = 1'b1; clear_flags = 1'b1;
      cyc();
      chk("setwins_unf", underflow, 1);
      clear_flags = 1'b1;
      cyc();
      chk("setwins_clr", underflow, 0);

      // reset with pending ret while stack non-empty
      call = 1'b1; load_value = 12'h700;
      cyc();
      chk("pre_rst_depth", depth, 1);
      ret = 1'b1; enable = 1'b1;
      call = 1'b1; load = 1'b1;
      reset = 1'b0;
      cyc();
      chk("rst2_pc", pc, 0);
      chk("rst2_depth", depth, 0);
      chk("rst2_top", top, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
